// File: rtl/mem_wb_elastic_stage_if.sv
// rtl/mem_wb_elastic_stage_if.sv - valid/ready bundle carrying one MEM/WB entry
interface mem_wb_elastic_stage_if #(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 2,
   parameter int ADDR_W = 5
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] read_data;
   logic [SEL_W-1:0]  wb_sel;
   logic              reg_write;
   logic [ADDR_W-1:0] rd_address;

   modport master (
      output valid, read_data, wb_sel, reg_write, rd_address,
      input  ready
   );

   modport slave (
      input  valid, read_data, wb_sel, reg_write, rd_address,
      output ready
   );
endinterface

// File: rtl/mem_wb_elastic_stage.sv
// rtl/mem_wb_elastic_stage.sv - MEM/WB elastic stage with flush, x0 suppression, stall counter; MEM_WB_SKID_EN adds a skid entry
module mem_wb_elastic_stage #(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 2,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   mem_wb_elastic_stage_if.slave    in_if,
   mem_wb_elastic_stage_if.master   out_if,
   output logic [CNT_W-1:0]         stall_count
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SEL_W-1:0]  sel;
      logic              rw;
      logic [ADDR_W-1:0] rd;
   } entry_t;

   entry_t            in_e;
   entry_t            main_q, main_d;
   logic              main_valid_q, main_valid_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              xfer_in;
   logic              main_free;

   assign main_free = !main_valid_q || out_if.ready;
   assign xfer_in   = in_if.valid && in_if.ready;

`ifdef MEM_WB_SKID_EN
   entry_t skid_q, skid_d;
   logic   skid_valid_q, skid_valid_d;

   // Registered ready: upstream never sees a combinational path from out_ready.
   assign in_if.ready = !skid_valid_q;
`else
   assign in_if.ready = main_free;
`endif

   always_comb begin
      in_e         = '{data: in_if.read_data, sel: in_if.wb_sel,
                       rw: in_if.reg_write, rd: in_if.rd_address};
      main_d       = main_q;
      main_valid_d = main_valid_q;
`ifdef MEM_WB_SKID_EN
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_free) begin
         // in_ready is low whenever the skid is full, so skid and input never compete.
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (xfer_in) begin
            main_d       = in_e;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (xfer_in) begin
         skid_d       = in_e;
         skid_valid_d = 1'b1;
      end
`else
      if (flush) begin
         main_valid_d = 1'b0;
      end else if (xfer_in) begin
         main_d       = in_e;
         main_valid_d = 1'b1;
      end else if (out_if.ready) begin
         main_valid_d = 1'b0;
      end
`endif
   end

   always_comb begin
      stall_d = stall_q;
      if (main_valid_q && !out_if.ready && !flush && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         stall_q      <= stall_d;
      end
   end

`ifdef MEM_WB_SKID_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`endif

   assign out_if.valid      = main_valid_q;
   assign out_if.read_data  = main_q.data;
   assign out_if.wb_sel     = main_q.sel;
   assign out_if.rd_address = main_q.rd;
   // Writes to x0 are architecturally discarded, so suppress them here.
   assign out_if.reg_write  = main_valid_q && main_q.rw && (main_q.rd != '0);
   assign stall_count       = stall_q;

endmodule

// File: tb/tb_mem_wb_elastic_stage.sv
// tb/tb_mem_wb_elastic_stage.sv - directed self-checking bench for mem_wb_elastic_stage
module tb_mem_wb_elastic_stage;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 2;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 4;

   logic             clk = 1'b0;
   logic             resetn;
   logic             flush;
   logic [CNT_W-1:0] stall_count;

   int n_cmp = 0;
   int n_err = 0;

   mem_wb_elastic_stage_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W)) u_in ();
   mem_wb_elastic_stage_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W)) u_out ();

   mem_wb_elastic_stage #(.DATA_W(DATA_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (flush),
      .in_if       (u_in),
      .out_if      (u_out),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [ADDR_W-1:0] rd,
                        input logic [DATA_W-1:0] d, input logic rw, input logic [SEL_W-1:0] sel);
      u_in.valid      = v;
      u_in.rd_address = rd;
      u_in.read_data  = d;
      u_in.reg_write  = rw;
      u_in.wb_sel     = sel;
   endtask

   int                q_rd[$];
   int                sent;
   int                recv;
   int                cyc;
   logic              ixf, oxf;

   initial begin
      resetn      = 1'b0;
      flush       = 1'b0;
      u_out.ready = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0);
      #2;
      chk("rst_valid", {31'd0, u_out.valid}, 32'd0);
      chk("rst_rd", {27'd0, u_out.rd_address}, 32'd0);
      chk("rst_data", u_out.read_data, 32'd0);
      chk("rst_rw", {31'd0, u_out.reg_write}, 32'd0);
      chk("rst_stall", {28'd0, stall_count}, 32'd0);
      step();
      resetn = 1'b1;

      // Reset asserted between edges while an entry is held and stalled
      drive(1'b1, 5'd5, 32'h55, 1'b1, 2'd1);
      step();
      chk("mid_valid_pre", {31'd0, u_out.valid}, 32'd1);
      chk("mid_rd_pre", {27'd0, u_out.rd_address}, 32'd5);
      drive(1'b0, '0, '0, 1'b0, '0);
      step();
      chk("mid_stall_pre", {28'd0, stall_count}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("mid_valid", {31'd0, u_out.valid}, 32'd0);
      chk("mid_rd", {27'd0, u_out.rd_address}, 32'd0);
      chk("mid_rw", {31'd0, u_out.reg_write}, 32'd0);
      chk("mid_stall", {28'd0, stall_count}, 32'd0);
      resetn = 1'b1;
      step();

      // Back-to-back stream with sink always ready
      u_out.ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, ADDR_W'(i), DATA_W'(i * 32'h11), 1'b1, SEL_W'(i));
         #1;
         chk("str_in_ready", {31'd0, u_in.ready}, 32'd1);
         step();
         chk("str_valid", {31'd0, u_out.valid}, 32'd1);
         chk("str_rd", {27'd0, u_out.rd_address}, i);
         chk("str_data", u_out.read_data, i * 32'h11);
         chk("str_sel", {30'd0, u_out.wb_sel}, i & 3);
         chk("str_rw", {31'd0, u_out.reg_write}, 32'd1);
      end
      drive(1'b0, '0, '0, 1'b0, '0);
      step();
      chk("str_drain", {31'd0, u_out.valid}, 32'd0);
      chk("str_hold_data", u_out.read_data, 32'h44);

      // Destination x0: payload visible, write suppressed
      drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 2'd1);
      step();
      chk("x0_valid", {31'd0, u_out.valid}, 32'd1);
      chk("x0_data", u_out.read_data, 32'hDEAD);
      chk("x0_rw", {31'd0, u_out.reg_write}, 32'd0);
      // reg_write captured fresh, not held from the previous entry
      drive(1'b1, 5'd6, 32'h66, 1'b0, 2'd2);
      step();
      chk("rw0_rd", {27'd0, u_out.rd_address}, 32'd6);
      chk("rw0_rw", {31'd0, u_out.reg_write}, 32'd0);
      drive(1'b0, '0, '0, 1'b0, '0);
      step();
      chk("rw0_drain", {31'd0, u_out.valid}, 32'd0);
      chk("rw0_hold_rd", {27'd0, u_out.rd_address}, 32'd6);

      // Stall: 3 cycles, then saturate the 4-bit counter
      drive(1'b1, 5'd9, 32'h99, 1'b1, 2'd0);
      step();
      drive(1'b0, '0, '0, 1'b0, '0);
      u_out.ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("stall_3", {28'd0, stall_count}, 32'd3);
      chk("stall_rd", {27'd0, u_out.rd_address}, 32'd9);
      chk("stall_data", u_out.read_data, 32'h99);
      chk("stall_valid", {31'd0, u_out.valid}, 32'd1);
`ifndef MEM_WB_SKID_EN
      chk("stall_in_ready", {31'd0, u_in.ready}, 32'd0);
`endif
      for (int i = 0; i < 17; i++) step();
      chk("stall_sat", {28'd0, stall_count}, 32'd15);
      step();
      chk("stall_sat2", {28'd0, stall_count}, 32'd15);

      // Flush with a held entry and a concurrent offer
      u_out.ready = 1'b1;
      drive(1'b1, 5'd3, 32'h33, 1'b1, 2'd0);
      step();
      chk("fl_pre_rd", {27'd0, u_out.rd_address}, 32'd3);
      u_out.ready = 1'b0;
      drive(1'b1, 5'd7, 32'h77, 1'b1, 2'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0);
      chk("fl_valid", {31'd0, u_out.valid}, 32'd0);
      chk("fl_rw", {31'd0, u_out.reg_write}, 32'd0);
      chk("fl_stall", {28'd0, stall_count}, 32'd15);
      u_out.ready = 1'b1;
      step();
      chk("fl_no_rd7", {31'd0, u_out.valid}, 32'd0);

      // Toggling sink with continuous source: order and no duplicates
      sent = 0;
      recv = 0;
      cyc  = 0;
      while ((recv < 6) && (cyc < 60)) begin
         u_out.ready = (cyc % 2) == 0;
         if (sent < 6)
            drive(1'b1, ADDR_W'(sent + 1), DATA_W'((sent + 1) * 32'h11), 1'b1, 2'd1);
         else
            drive(1'b0, '0, '0, 1'b0, '0);
         #1;
`ifdef MEM_WB_SKID_EN
         chk("tog_in_ready", {31'd0, u_in.ready}, (q_rd.size() < 2) ? 32'd1 : 32'd0);
`endif
         ixf = u_in.valid && u_in.ready;
         oxf = u_out.valid && u_out.ready;
         if (oxf) begin
            if (q_rd.size() == 0) begin
               chk("tog_dup", {27'd0, u_out.rd_address}, 32'd0);
            end else begin
               chk("tog_rd", {27'd0, u_out.rd_address}, q_rd[0]);
               chk("tog_data", u_out.read_data, q_rd[0] * 32'h11);
               void'(q_rd.pop_front());
            end
            recv++;
         end
         if (ixf) begin
            q_rd.push_back(sent + 1);
            sent++;
         end
         step();
         cyc++;
      end
      chk("tog_done", recv, 32'd6);
      chk("tog_sent", sent, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
